perceptron_trainer: RTL
=======================

# perceptron_trainer

Sequential training stage placed directly upstream of the `neuron` block. It runs the online perceptron learning rule over the four 2-input binary samples of a programmable truth table. It produces the sign-magnitude Q15.16 weights `W1`, `W2` and `WB` that the neuron consumes. Training stops when an epoch completes with zero errors or when the epoch limit is reached.

## Interface
Parameters:
- `Q_M`, 15, integer bits of the weight format.
- `Q_N`, 16, fraction bits; word width = 1 + Q_M + Q_N = 32; bit 31 = sign, bits 30:0 = magnitude.
- `W1_INIT`, `W2_INIT`, `WB_INIT`, 0, initial weights, sign-magnitude.
- `LEARN_RATE`, 32'h0000_199A (about 0.1), positive step size, sign-magnitude.
- `TARGETS`, 4'b1110 (OR), bit i = target output for sample i = {x1,x2}.
- `MAX_EPOCHS`, 64, epoch limit, ≥1.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  request a training run; sampled in IDLE only.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse, high in the DONE cycle.
- `converged_o`  out  1  last run ended with an error-free epoch; held until the next start.
- `epoch_o`  out  $clog2(MAX_EPOCHS+1)  epochs completed in the current or last run.
- `weights_valid_o`  out  1  high in IDLE after a completed run; cleared on start.
- `w1_o`, `w2_o`, `wb_o`  out  32  live weight registers, sign-magnitude.

## Operation
- States and transitions:
  - IDLE → EVAL when `start_i`=1.
  - EVAL → UPDATE.
  - UPDATE → EVAL if sample < 3, else → EPOCH_END.
  - EPOCH_END → DONE if error count = 0 or epoch = MAX_EPOCHS, else → EVAL.
  - DONE → IDLE.
- Start actions:
  - Clear `epoch_o`, `converged_o` and `weights_valid_o`.
  - Sample index = 0.
  - Weights reload from the INIT parameters (see Configuration).
- Sample order is 00, 01, 10, 11 (x1 is the MSB). The bias input is constant 1.
- EVAL:
  - sum = WB + x1·W1 + x2·W2, evaluated in 34-bit two's complement.
  - y = 1 iff sum > 0; a zero sum gives 0. This matches the neuron's firing rule.
- UPDATE:
  - e = target − y ∈ {−1, 0, +1}.
  - For each weight with active input (bias always active): w += e·LEARN_RATE.
  - Error counter increments when e ≠ 0.
  - Updates are online: the next sample uses the updated weights.
- Weight arithmetic:
  - Convert to two's complement, add, then convert back.
  - Magnitude saturates at 2^31−1.
  - −0 is normalised to +0.
- EPOCH_END: `epoch_o` increments; the error counter is cleared after the decision.
- DONE: `converged_o` = (last epoch error count == 0).
- `start_i` is ignored outside IDLE. If `start_i` is still high on return to IDLE, a new run starts.
- Reset values:
  - Weights = INIT.
  - All flags 0; `epoch_o` = 0; state = IDLE.
  - Reset mid-run aborts immediately. No partial result is kept.

## Timing
- Start is accepted on edge k. `busy_o` is high from cycle k+1.
- Each sample takes 2 cycles; each epoch takes 9 cycles.
- With N epochs, `done_o` is high in cycle k+1+9N. IDLE is entered on the following cycle.
- Weight outputs change only on UPDATE exit edges, reset, and start reload.
- `weights_valid_o` rises on entry to IDLE from DONE.

## Configuration
- `TRAINER_KEEP_WEIGHTS_EN` defined: start does not reload INIT. Training continues from the current weights. Reset still loads INIT.
- Undefined: every start reloads `W1_INIT`, `W2_INIT`, `WB_INIT`.

## Test plan
- Default parameters, start: converges after 4 epochs.
  - `epoch_o`=4, `converged_o`=1.
  - `w1_o`=`w2_o`=32'h0000_199A, `wb_o`=0.
  - `done_o` pulses exactly 37 cycles after the start edge.
- `TARGETS`=4'b0110 (XOR), `MAX_EPOCHS`=8: `done_o` at cycle 73, `converged_o`=0, `epoch_o`=8.
- Saturation setup: `W1_INIT`=32'h7FFF_FFFF, `WB_INIT`=32'hFFFF_FFFF, `TARGETS`=4'b0100, `MAX_EPOCHS`=1.
  - Final `w1_o`=32'h7FFF_E665, `w2_o`=32'h8000_199A, `wb_o`=32'hFFFF_FFFF.
  - Check that no weight wraps at any point.
- `rst_ni` low for 1 cycle during epoch 2 of the default run: all outputs return to reset values asynchronously. A new start then reproduces the first test's result and timing.
- Pulse `start_i` during EVAL, UPDATE and DONE: ignored, no restart, timing unchanged.
  - Hold `start_i`=1 continuously: a back-to-back run begins on the cycle after DONE.
- `TRAINER_KEEP_WEIGHTS_EN` defined, second start after the default run converges:
  - Result: `epoch_o`=1, `converged_o`=1, weights unchanged.
  - `done_o` at 10 cycles after start.

Source files
------------

// File: rtl/perceptron_trainer.sv
// perceptron_trainer: online perceptron training over a programmable 2-input
// truth table, producing sign-magnitude Q15.16 weights for the neuron stage.
// Optional build macro: TRAINER_KEEP_WEIGHTS_EN (start keeps current weights
// instead of reloading the INIT values; reset still loads INIT).
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | waiting for start_i; results of the last run are held
// S_EVAL      | compute sum/firing decision for the current sample
// S_UPDATE    | apply e*LEARN_RATE to active weights, advance sample
// S_EPOCH_END | count the epoch, decide between another epoch and DONE
// S_DONE      | one-cycle completion pulse
module perceptron_trainer #(
  parameter int               Q_M        = 15,
  parameter int               Q_N        = 16,
  parameter logic [Q_M+Q_N:0] W1_INIT    = '0,
  parameter logic [Q_M+Q_N:0] W2_INIT    = '0,
  parameter logic [Q_M+Q_N:0] WB_INIT    = '0,
  parameter logic [Q_M+Q_N:0] LEARN_RATE = 32'h0000_199A,
  parameter logic [3:0]       TARGETS    = 4'b1110,
  parameter int               MAX_EPOCHS = 64
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            converged_o,
  output logic [$clog2(MAX_EPOCHS+1)-1:0] epoch_o,
  output logic                            weights_valid_o,
  output logic [Q_M+Q_N:0]                w1_o,
  output logic [Q_M+Q_N:0]                w2_o,
  output logic [Q_M+Q_N:0]                wb_o
);

  localparam int W  = 1 + Q_M + Q_N;
  // Two guard bits: the three-term sum never overflows WX-bit two's complement.
  localparam int WX = W + 2;
  localparam int EW = $clog2(MAX_EPOCHS + 1);
  localparam logic [WX-1:0] MAG_MAX = {3'b000, {(W-1){1'b1}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_UPDATE,
    S_EPOCH_END,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sample_q;
  logic            y_q;
  logic [2:0]      err_q;
  logic [EW-1:0]   epoch_q;
  logic            conv_q;
  logic            valid_q;
  logic [W-1:0]    w1_q, w2_q, wb_q;

  logic            x1, x2, target;
  logic            err_pos, err_neg;
  logic            last_epoch;
  logic            fire;
  logic [WX-1:0]   sum;

  function automatic logic [WX-1:0] to_tc(input logic [W-1:0] v);
    logic [WX-1:0] m;
    m = {3'b000, v[W-2:0]};
    return v[W-1] ? (~m + WX'(1)) : m;
  endfunction

  // Back to sign-magnitude with magnitude clamp; a zero result is always +0.
  function automatic logic [W-1:0] to_sm(input logic [WX-1:0] v);
    logic [WX-1:0] m;
    m = v[WX-1] ? (~v + WX'(1)) : v;
    if (m > MAG_MAX) m = MAG_MAX;
    return {v[WX-1] && (m != '0), m[W-2:0]};
  endfunction

  function automatic logic [W-1:0] step(input logic [W-1:0] w, input logic dec);
    logic [WX-1:0] lr;
    lr = to_tc(LEARN_RATE);
    return to_sm(dec ? (to_tc(w) - lr) : (to_tc(w) + lr));
  endfunction

  assign x1      = sample_q[1];
  assign x2      = sample_q[0];
  assign target  = TARGETS[sample_q];
  assign err_pos = target & ~y_q;
  assign err_neg = ~target & y_q;
  assign last_epoch = (err_q == 3'd0) || (epoch_q == EW'(MAX_EPOCHS - 1));

  // Weighted sum of the current sample with the bias input fixed at 1.
  always_comb begin
    sum  = to_tc(wb_q) + (x1 ? to_tc(w1_q) : '0) + (x2 ? to_tc(w2_q) : '0);
    fire = ~sum[WX-1] && (sum != '0);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and status outputs.
  always_comb begin
    state_d = state_q;
    busy_o  = (state_q != S_IDLE);
    done_o  = (state_q == S_DONE);
    case (state_q)
      S_IDLE:      if (start_i) state_d = S_EVAL;
      S_EVAL:      state_d = S_UPDATE;
      S_UPDATE:    state_d = (sample_q == 2'd3) ? S_EPOCH_END : S_EVAL;
      S_EPOCH_END: state_d = last_epoch ? S_DONE : S_EVAL;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath: sample/epoch bookkeeping, result flags and weight updates.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_q <= 2'd0;
      y_q      <= 1'b0;
      err_q    <= 3'd0;
      epoch_q  <= '0;
      conv_q   <= 1'b0;
      valid_q  <= 1'b0;
      w1_q     <= W1_INIT;
      w2_q     <= W2_INIT;
      wb_q     <= WB_INIT;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sample_q <= 2'd0;
            err_q    <= 3'd0;
            epoch_q  <= '0;
            conv_q   <= 1'b0;
            valid_q  <= 1'b0;
`ifdef TRAINER_KEEP_WEIGHTS_EN
`else
            w1_q     <= W1_INIT;
            w2_q     <= W2_INIT;
            wb_q     <= WB_INIT;
`endif
          end
        end
        S_EVAL: y_q <= fire;
        S_UPDATE: begin
          sample_q <= sample_q + 2'd1;
          if (err_pos || err_neg) begin
            err_q <= err_q + 3'd1;
            wb_q  <= step(wb_q, err_neg);
            if (x1) w1_q <= step(w1_q, err_neg);
            if (x2) w2_q <= step(w2_q, err_neg);
          end
        end
        S_EPOCH_END: begin
          epoch_q <= epoch_q + EW'(1);
          err_q   <= 3'd0;
          if (last_epoch) conv_q <= (err_q == 3'd0);
        end
        S_DONE:  valid_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign converged_o     = conv_q;
  assign epoch_o         = epoch_q;
  assign weights_valid_o = valid_q;
  assign w1_o            = w1_q;
  assign w2_o            = w2_q;
  assign wb_o            = wb_q;

endmodule
